// File: rtl/acc_drain_if.sv
// Accumulator read port and unified-buffer write port of the drain stage.
// master = drain engine, slave = accumulator bank / unified buffer side.
interface acc_drain_if #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int IDX_WIDTH  = 4,
  parameter int ADDR_WIDTH = 8
);
  logic                  acc_rd_en;
  logic [IDX_WIDTH-1:0]  acc_rd_index;
  logic [ACC_WIDTH-1:0]  acc_rd_data;
  logic                  ub_wr_valid;
  logic                  ub_wr_ready;
  logic [ADDR_WIDTH-1:0] ub_wr_addr;
  logic [OUT_WIDTH-1:0]  ub_wr_data;

  modport master (
    output acc_rd_en, acc_rd_index,
    input  acc_rd_data,
    output ub_wr_valid, ub_wr_addr, ub_wr_data,
    input  ub_wr_ready
  );

  modport slave (
    input  acc_rd_en, acc_rd_index,
    output acc_rd_data,
    input  ub_wr_valid, ub_wr_addr, ub_wr_data,
    output ub_wr_ready
  );
endinterface

// File: rtl/acc_drain.sv
// Accumulator drain: reads a run of accumulator entries, rescales each with a
// rounding arithmetic shift, optional ReLU, saturates to OUT_WIDTH and writes
// the results to the unified buffer at consecutive addresses.
module acc_drain #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int DEPTH      = 4,
  parameter int IDX_WIDTH  = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  first_index,
  input  logic [IDX_WIDTH:0]    count,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  acc_drain_if.master           bus,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [IDX_WIDTH:0]   DEPTH_CNT = (IDX_WIDTH+1)'(DEPTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(DEPTH - 1);
  // Saturation bounds expressed at the widened arithmetic width.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [2:0]            state_reg, state_next;
  logic [IDX_WIDTH-1:0]  idx_reg;
  logic [IDX_WIDTH:0]    n_reg;
  logic [IDX_WIDTH:0]    count_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [4:0]            shift_reg;
  logic                  relu_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [OUT_WIDTH-1:0]  data_reg;

  logic [IDX_WIDTH:0]    count_clamped;
  logic                  last_entry;
  logic [IDX_WIDTH-1:0]  idx_next;
  logic [OUT_WIDTH-1:0]  result_next;

  // A first_index beyond the bank still lands on a real entry.
  function automatic logic [IDX_WIDTH-1:0] wrap_index(input logic [IDX_WIDTH-1:0] v);
    wrap_index = IDX_WIDTH'(32'(v) % 32'(DEPTH));
  endfunction

  assign count_clamped = (count > DEPTH_CNT) ? DEPTH_CNT : count;
  assign last_entry    = ((n_reg + 1'b1) >= count_reg);
  assign idx_next      = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;

  // Rescale the returned partial sum: round-half-up shift, ReLU, saturate.
  always_comb begin
    logic signed [ACC_WIDTH:0] x_ext;
    logic signed [ACC_WIDTH:0] half;
    logic signed [ACC_WIDTH:0] shifted;
    x_ext = {bus.acc_rd_data[ACC_WIDTH-1], bus.acc_rd_data};
    half  = '0;
    if (shift_reg != 5'd0) begin
      half[{1'b0, shift_reg} - 6'd1] = 1'b1;
    end
    shifted = (x_ext + half) >>> shift_reg;
    if (relu_reg && (shifted < 0)) begin
      shifted = '0;
    end
    if (shifted > SAT_MAX) begin
      result_next = SAT_MAX[OUT_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      result_next = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      result_next = shifted[OUT_WIDTH-1:0];
    end
  end

  // Next-state logic; ready only matters while a write is pending.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = (count_clamped == '0) ? S_FIN : S_READ;
      S_READ:  state_next = S_CAPT;
      S_CAPT:  state_next = S_WRITE;
      S_WRITE: if (bus.ub_wr_ready) state_next = last_entry ? S_FIN : S_READ;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register and run context; reset abandons any run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      n_reg     <= '0;
      count_reg <= '0;
      base_reg  <= '0;
      shift_reg <= '0;
      relu_reg  <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            idx_reg   <= wrap_index(first_index);
            n_reg     <= '0;
            count_reg <= count_clamped;
            base_reg  <= base_addr;
            shift_reg <= shift;
            relu_reg  <= relu_en;
          end
        end
        S_CAPT: begin
          data_reg <= result_next;
          addr_reg <= base_reg + ADDR_WIDTH'(n_reg);
        end
        S_WRITE: begin
          if (bus.ub_wr_ready && !last_entry) begin
            n_reg   <= n_reg + 1'b1;
            idx_reg <= idx_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.acc_rd_en    = (state_reg == S_READ);
  assign bus.acc_rd_index = idx_reg;
  assign bus.ub_wr_valid  = (state_reg == S_WRITE);
  assign bus.ub_wr_addr   = addr_reg;
  assign bus.ub_wr_data   = data_reg;
  assign busy             = (state_reg != S_IDLE);
  assign done             = (state_reg == S_FIN);

endmodule

// File: tb/tb_acc_drain.sv
// Scoreboard bench for acc_drain: expected reads/writes are queued when a run
// is started and checked by the monitor as the DUT produces them.
module tb_acc_drain;
  localparam int ACC_WIDTH  = 32;
  localparam int OUT_WIDTH  = 16;
  localparam int DEPTH      = 4;
  localparam int IDX_WIDTH  = 4;
  localparam int ADDR_WIDTH = 8;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [IDX_WIDTH-1:0]  first_index;
  logic [IDX_WIDTH:0]    count;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [4:0]            shift;
  logic                  relu_en;
  logic                  busy;
  logic                  done;

  acc_drain_if #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
                 .IDX_WIDTH(IDX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  acc_drain #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH),
              .IDX_WIDTH(IDX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_index (first_index),
    .count       (count),
    .base_addr   (base_addr),
    .shift       (shift),
    .relu_en     (relu_en),
    .bus         (bus),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc, done_cyc, done_cnt = 0, done_base;
  int wr_n, rd_n;
  string tname = "init";
  logic signed [31:0] mem [0:3];
  wr_t exp_wr[$];
  int  exp_rd[$];
  int  wr_cyc[$];
  int  rd_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator bank model: one-cycle read latency.
  always @(posedge clk) if (bus.acc_rd_en) bus.acc_rd_data <= mem[bus.acc_rd_index];

  // Monitor: pops the scoreboard for every read strobe and every transfer.
  always @(negedge clk) begin
    if (bus.acc_rd_en) begin
      int e;
      rd_n++;
      rd_cyc.push_back(cyc);
      n_cmp++;
      if (exp_rd.size() == 0) begin
        n_err++;
        $display("FAIL %s rd_index: got %0d, required no read", tname, bus.acc_rd_index);
      end else begin
        e = exp_rd.pop_front();
        if (int'(bus.acc_rd_index) !== e) begin
          n_err++;
          $display("FAIL %s rd_index: got %0d, required %0d", tname, bus.acc_rd_index, e);
        end
      end
    end
    if (bus.ub_wr_valid && bus.ub_wr_ready) begin
      wr_t w;
      wr_n++;
      wr_cyc.push_back(cyc);
      $display("[%s] write addr=%02h data=%0d", tname, bus.ub_wr_addr, $signed(bus.ub_wr_data));
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_err++;
        $display("FAIL %s write: got addr %02h data %h, required no write", tname,
                 bus.ub_wr_addr, bus.ub_wr_data);
      end else begin
        w = exp_wr.pop_front();
        if (bus.ub_wr_addr !== w.addr || bus.ub_wr_data !== w.data) begin
          n_err++;
          $display("FAIL %s write: got addr %02h data %h, required addr %02h data %h", tname,
                   bus.ub_wr_addr, bus.ub_wr_data, w.addr, w.data);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference rescale: floor division of the rounded value.
  function automatic logic [15:0] model(input longint x, input int sh, input bit relu);
    longint r, num, d;
    if (sh == 0) r = x;
    else begin
      num = x + (longint'(1) << (sh - 1));
      d   = longint'(1) << sh;
      r   = num / d;
      if ((num % d) != 0 && num < 0) r = r - 1;
    end
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic clear_sb();
    exp_wr.delete(); exp_rd.delete(); wr_cyc.delete(); rd_cyc.delete();
    wr_n = 0; rd_n = 0;
  endtask

  task automatic push_model(input int fi, input int cnt, input int base, input int sh, input bit relu);
    int n;
    wr_t w;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (fi + k) % DEPTH;
      exp_rd.push_back(idx);
      w.addr = 8'(base + k);
      w.data = model(longint'(mem[idx]), sh, relu);
      exp_wr.push_back(w);
    end
  endtask

  // Drives a one-cycle start, then scrambles the command inputs.
  task automatic start_run(input int fi, input int cnt, input int base, input int sh, input bit relu);
    @(posedge clk); #1;
    first_index = 4'(fi); count = 5'(cnt); base_addr = 8'(base);
    shift = 5'(sh); relu_en = relu; start = 1'b1;
    start_cyc = cyc; done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    first_index = 4'($urandom); count = 5'($urandom); base_addr = 8'($urandom);
    shift = 5'($urandom); relu_en = 1'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cnt != done_base) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    tname = "reset";
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b, required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b, required 0", done); end
    n_cmp++; if (bus.ub_wr_valid !== 1'b0) begin n_err++; $display("FAIL reset valid: got %b, required 0", bus.ub_wr_valid); end
    n_cmp++; if (bus.acc_rd_en !== 1'b0) begin n_err++; $display("FAIL reset rd_en: got %b, required 0", bus.acc_rd_en); end
    n_cmp++; if ({bus.ub_wr_addr, bus.ub_wr_data, bus.acc_rd_index} !== 28'h0) begin
      n_err++; $display("FAIL reset buses: got addr %h data %h idx %h, required 0", bus.ub_wr_addr, bus.ub_wr_data, bus.acc_rd_index);
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single();
    bit to;
    tname = "single"; clear_sb(); bus.ub_wr_ready = 1'b1;
    mem[0] = 1234;
    exp_rd.push_back(0); exp_wr.push_back({8'h10, 16'd1234});
    start_run(0, 1, 'h10, 0, 0);
    wait_done(30, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL single timeout: got no done, required done"); end
    n_cmp++; if (done_cyc - start_cyc !== 4) begin n_err++; $display("FAIL single latency: got %0d, required 4", done_cyc - start_cyc); end
    n_cmp++; if (wr_n !== 1 || rd_n !== 1 || exp_wr.size() != 0) begin
      n_err++; $display("FAIL single counts: got wr %0d rd %0d, required 1 1", wr_n, rd_n);
    end
  endtask

  task automatic test_wrap();
    bit to;
    tname = "wrap"; clear_sb(); bus.ub_wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = i * 100;
    push_model(2, 4, 'hFE, 0, 0);
    start_run(2, 4, 'hFE, 0, 0);
    wait_done(60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL wrap timeout: got no done, required done"); end
    n_cmp++; if (done_cyc - start_cyc !== 13) begin n_err++; $display("FAIL wrap latency: got %0d, required 13", done_cyc - start_cyc); end
    n_cmp++; if (wr_n !== 4 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      n_err++; $display("FAIL wrap counts: got wr %0d left %0d, required 4 0", wr_n, exp_wr.size());
    end
  endtask

  task automatic test_arith();
    int xs [9] = '{40, -40, -41, 100000, -100000, -5, 32'h7FFFFFFF, -5, 1000};
    int ss [9] = '{4, 4, 4, 0, 0, 0, 31, 0, 2};
    bit rs [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
    int es [9] = '{3, -2, -3, 32767, -32768, 0, 1, -5, 250};
    bit to;
    tname = "arith"; bus.ub_wr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      clear_sb();
      mem[0] = xs[i];
      exp_rd.push_back(0); exp_wr.push_back({8'h00, 16'(es[i])});
      start_run(0, 1, 0, ss[i], rs[i]);
      wait_done(30, to);
      n_cmp++; if (to || wr_n !== 1) begin n_err++; $display("FAIL arith case%0d: got wr %0d timeout %b, required 1 0", i, wr_n, to); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    tname = "backpressure"; clear_sb(); bus.ub_wr_ready = 1'b0;
    mem[1] = -7000; mem[2] = 555;
    push_model(1, 2, 'h40, 1, 0);
    start_run(1, 2, 'h40, 1, 0);
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.ub_wr_valid) begin to = 1'b0; break; end end
    n_cmp++; if (to) begin n_err++; $display("FAIL bp valid_timeout: got no valid, required valid"); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (exp_wr.size() == 0 || bus.ub_wr_valid !== 1'b1 ||
          bus.ub_wr_addr !== exp_wr[0].addr || bus.ub_wr_data !== exp_wr[0].data) begin
        n_err++; $display("FAIL bp stall%0d: got valid %b addr %02h data %h, required stable pending write", k,
                          bus.ub_wr_valid, bus.ub_wr_addr, bus.ub_wr_data);
      end
    end
    n_cmp++; if (rd_n !== 1) begin n_err++; $display("FAIL bp stall_reads: got %0d, required 1", rd_n); end
    bus.ub_wr_ready = 1'b1;
    wait_done(40, to);
    n_cmp++; if (to || wr_n !== 2 || exp_wr.size() != 0) begin
      n_err++; $display("FAIL bp writes: got %0d timeout %b, required 2 0", wr_n, to);
    end
    n_cmp++; if (rd_cyc.size() < 2 || wr_cyc.size() < 1 || rd_cyc[1] <= wr_cyc[0]) begin
      n_err++; $display("FAIL bp read_order: got rds %0d wrs %0d, required 2nd read after 1st transfer", rd_cyc.size(), wr_cyc.size());
    end
  endtask

  task automatic test_count0();
    bit to;
    tname = "count0"; clear_sb(); bus.ub_wr_ready = 1'b1;
    start_run(1, 0, 'h33, 0, 0);
    wait_done(20, to);
    repeat (3) @(negedge clk);
    n_cmp++; if (to || done_cyc - start_cyc !== 1) begin n_err++; $display("FAIL count0 done: got latency %0d timeout %b, required 1 0", done_cyc - start_cyc, to); end
    n_cmp++; if (rd_n !== 0 || wr_n !== 0) begin n_err++; $display("FAIL count0 traffic: got rd %0d wr %0d, required 0 0", rd_n, wr_n); end
  endtask

  task automatic test_clamp();
    bit to;
    tname = "clamp"; clear_sb(); bus.ub_wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(-3000 * i + 77);
    push_model(3, 7, 'h90, 2, 1);
    start_run(3, 7, 'h90, 2, 1);
    wait_done(80, to);
    repeat (3) @(negedge clk);
    n_cmp++; if (to || wr_n !== 4 || exp_wr.size() != 0) begin n_err++; $display("FAIL clamp writes: got %0d timeout %b, required 4 0", wr_n, to); end
  endtask

  task automatic test_start_ignored();
    tname = "start_ignored"; clear_sb(); bus.ub_wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 1111 - 2000);
    push_model(0, 3, 'h80, 1, 0);
    start_run(0, 3, 'h80, 1, 0);
    repeat (3) @(posedge clk); #1;
    start = 1'b1; first_index = 4'd3; count = 5'd1; base_addr = 8'h00;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < start_cyc + 10) begin @(posedge clk); #1; end
    start = 1'b1; count = 5'd2; base_addr = 8'h55;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (done_cnt - done_base !== 1 || done_cyc - start_cyc !== 10) begin
      n_err++; $display("FAIL start_ignored done: got %0d pulses at %0d, required 1 at 10", done_cnt - done_base, done_cyc - start_cyc);
    end
    n_cmp++; if (wr_n !== 3 || rd_n !== 3 || exp_wr.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL start_ignored traffic: got wr %0d rd %0d busy %b, required 3 3 0", wr_n, rd_n, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    tname = "reset_mid"; clear_sb(); bus.ub_wr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(-50000 + i * 40000);
    start_run(0, 4, 'h20, 0, 0);
    exp_rd.push_back(0);
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.ub_wr_valid) begin to = 1'b0; break; end end
    n_cmp++; if (to) begin n_err++; $display("FAIL reset_mid valid_timeout: got no valid, required valid"); end
    @(posedge clk); #2; reset = 1'b1; #1;
    n_cmp++; if (bus.ub_wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_mid async: got valid %b busy %b done %b, required 0 0 0", bus.ub_wr_valid, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0; clear_sb(); done_base = done_cnt;
    repeat (2) @(negedge clk);
    n_cmp++; if (done_cnt !== done_base || wr_n !== 0) begin n_err++; $display("FAIL reset_mid quiet: got done %0d wr %0d, required 0 0", done_cnt - done_base, wr_n); end
    bus.ub_wr_ready = 1'b1;
    push_model(2, 2, 'h30, 4, 1);
    start_run(2, 2, 'h30, 4, 1);
    wait_done(40, to);
    n_cmp++; if (to || wr_n !== 2 || exp_wr.size() != 0 || done_cyc - start_cyc !== 7) begin
      n_err++; $display("FAIL reset_mid rerun: got wr %0d latency %0d timeout %b, required 2 7 0", wr_n, done_cyc - start_cyc, to);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; first_index = '0; count = '0; base_addr = '0;
    shift = '0; relu_en = 1'b0; bus.ub_wr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 0;
    test_reset();
    test_single();
    test_wrap();
    test_arith();
    test_backpressure();
    test_count0();
    test_clamp();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/acc_drain.md
Name: acc_drain

Overview:
Writeback stage directly downstream of the accumulator bank. On a start command it reads a run of accumulator entries one at a time. Each 32-bit signed partial sum is rescaled with a rounding arithmetic shift, optionally passed through ReLU, and saturated to 16 bits. Each result is then written to the unified buffer over a valid/ready handshake at consecutive addresses.

Parameters:
ACC_WIDTH, 32, accumulator entry width (signed)
OUT_WIDTH, 16, result width written to unified buffer (signed)
DEPTH, 4, number of accumulator entries
IDX_WIDTH, 4, accumulator index width
ADDR_WIDTH, 8, unified buffer address width

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
start  input  1  one-cycle command pulse; ignored unless idle
first_index  input  IDX_WIDTH  first accumulator entry to drain
count  input  IDX_WIDTH+1  number of entries to drain (0..DEPTH)
base_addr  input  ADDR_WIDTH  unified buffer address for first result
shift  input  5  right-shift amount, 0..31
relu_en  input  1  clamp negative results to 0
acc_rd_en  output  1  accumulator read strobe
acc_rd_index  output  IDX_WIDTH  accumulator entry being read
acc_rd_data  input  ACC_WIDTH  read data, valid the cycle after acc_rd_en
ub_wr_valid  output  1  write request
ub_wr_ready  input  1  unified buffer accepts write
ub_wr_addr  output  ADDR_WIDTH  write address
ub_wr_data  output  OUT_WIDTH  write data
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse when the run completes

Behaviour:
- Reset values: all outputs 0; FSM to IDLE; internal counters 0. Reset mid-run aborts immediately. No partial state survives reset, and no done pulse is produced.
- On start in IDLE, latch first_index, count, base_addr, shift and relu_en. Later changes to these inputs have no effect until the next start.
- count > DEPTH is clamped to DEPTH.
- Index wraps modulo DEPTH: entry = (first_index + n) mod DEPTH. Address wraps modulo 2^ADDR_WIDTH.
- FSM states and transitions:
  - IDLE: on start, go to READ. If the latched count is 0, go to FIN instead.
  - READ: drive acc_rd_en=1 and acc_rd_index = current entry for exactly one cycle. Go to CAPT.
  - CAPT: sample acc_rd_data, compute the result, and register it into ub_wr_data. Register base_addr+n into ub_wr_addr. Set ub_wr_valid=1. Go to WRITE.
  - WRITE: hold valid, addr and data stable until a cycle with ub_wr_ready=1. In that cycle the transfer occurs; next cycle valid=0. If n+1 < count, increment n and go to READ; otherwise go to FIN.
  - FIN: done=1 for one cycle. Go to IDLE.
- Throughput: 3 cycles per entry with ready held high. A run of N entries completes in 3N+2 cycles from start to the done pulse, inclusive.
- ub_wr_ready is ignored outside WRITE. ready already high on entry to WRITE completes the transfer that cycle.
- start while busy is ignored, including start in the same cycle as done.
- busy is 1 in READ, CAPT, WRITE and FIN.
- Arithmetic (signed, evaluated at ACC_WIDTH+1 bits to avoid rounding overflow):
  - shift = 0: r = x.
  - shift > 0: r = (x + 2^(shift-1)) >>> shift, arithmetic, round-half-up.
  - If relu_en and r < 0: r = 0.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Exactly one ub write occurs per drained entry. Writes occur in index order, and no write is duplicated or dropped under any ready pattern.

Test Plan:
- Single entry, ready tied high: start with first_index=0, count=1, base_addr=0x10, shift=0, relu_en=0, rd_data=1234 -> acc_rd_en one cycle with index 0; one write addr 0x10 data 1234; done 5 cycles after start.
- Full run with wrap, ready tied high: first_index=2, count=4, base_addr=0xFE, rd_data per index = index*100 -> reads in index order 2,3,0,1; addrs FE,FF,00,01; data 200,300,0,100; done at cycle 14.
- Rounding, saturation and ReLU:
  - shift=4: x=40 -> 3; x=-40 -> -2; x=-41 -> -3.
  - shift=0: x=100000 -> 32767; x=-100000 -> -32768.
  - shift=0, relu_en=1: x=-5 -> 0.
  - shift=31: x=0x7FFFFFFF -> 1.
- Backpressure: ready low for 5 cycles then high, count=2 -> valid, addr and data stable throughout the stall; exactly 2 writes; second acc_rd_en only after the first transfer.
- Edge commands: count=0 -> done pulse with no reads or writes. count=7 -> clamped to 4 writes. start pulsed during a run -> ignored, run unaffected.
- Reset mid-run: assert reset in WRITE with valid high -> valid, busy and done drop to 0 asynchronously. A following start runs cleanly from the newly latched inputs.
